fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//  Controls program_counter and the instruction-memory fetch port. Drives pc_hold/pc_src/pc_target
//  from a 4-state FSM: sequential fetch, fetch stall, branch/jump redirect, imem-ack timeout.
//  Sits between the hazard unit / execute-stage redirect and program_counter + instruction memory.
//  Delivers instructions to decode as single-cycle valid pulses.
// PARAMETERS
//  INST_MEMORY_ADDRESS_WIDTH  from riscv_pkg  PC / imem address width
//  RISC_V_INST_WIDTH          32              instruction word width
//  TIMEOUT_CYCLES             64              max consecutive un-acked REQ cycles; 0 = check disabled
// PORTS
//  clk              in   1      clock; all state updates on posedge
//  rst              in   1      asynchronous, active-low reset (0 = in reset)
//  stall            in   1      hazard unit: freeze fetch
//  redirect_valid   in   1      one-cycle pulse: taken branch/jump from execute
//  redirect_target  in   AW     target address, sampled when redirect_valid=1
//  imem_ack         in   1      imem: imem_rdata valid this cycle
//  imem_rdata       in   IW     fetched instruction word
//  imem_req         out  1      fetch request for the current PC
//  pc_hold          out  1      to program_counter
//  pc_src           out  1      to program_counter: 1 = load pc_target
//  pc_target        out  AW     to program_counter inst_offset_addr
//  inst_valid       out  1      registered one-cycle pulse: inst_data valid
//  inst_data        out  IW     instruction to decode
//  flush            out  1      kill younger pipeline contents (high in REDIR)
//  fetch_error      out  1      sticky: imem timeout seen
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, imem_req=0, pc_hold=1, pc_src=0, pc_target=0, inst_valid=0,
//   inst_data=0, flush=0, fetch_error=0, pending redirect cleared, timeout counter=0.
//  pc_hold/pc_src/pc_target/imem_req/flush: combinational from state + inputs. All other outputs registered.
//  Redirect capture: redirect_valid=1 in any state loads pend_valid=1 and pend_target.
//   A newer pulse overwrites an older pending target. Priority: redirect > stall.
//  IDLE:  pc_hold=1, imem_req=0. Unconditional -> REQ after one cycle.
//   A redirect seen in IDLE stays pending and is taken from REQ.
//  REQ:   imem_req=1, held until imem_ack. Without ack: pc_hold=1; timeout counter increments.
//   ack & (pend_valid|redirect_valid): discard rdata, no inst_valid, pc_hold=1 -> REDIR.
//   ack & stall: buf<=imem_rdata, pc_hold=1 -> HOLD.
//   ack & !stall: inst_data<=imem_rdata, inst_valid=1 next cycle, pc_hold=0, pc_src=0 (PC+4), stay REQ.
//   Throughput: 1 instr/cycle when imem_ack is same-cycle.
//  HOLD:  imem_req=0, pc_hold=1.
//   redirect_valid|pend_valid: drop buf -> REDIR.
//   !stall: inst_data<=buf, inst_valid pulse, pc_hold=0, pc_src=0 -> REQ.
//  REDIR: imem_req=0, pc_hold=0, pc_src=1, pc_target=pend_target, flush=1. Stall ignored.
//   Clears pend_valid unless a new redirect_valid arrives this cycle; that pulse stays pending.
//   -> REQ.
//  Latency: redirect in HOLD, or REQ with ack, at cycle N -> REDIR at N+1 -> PC=target after
//   the N+1 edge -> imem_req for target at N+2.
//   In REQ without ack, the redirect waits for ack. The imem handshake is never abandoned.
//  Timeout: counter counts consecutive REQ cycles with imem_ack=0; cleared on ack or leaving REQ.
//   Reaching TIMEOUT_CYCLES sets fetch_error (sticky until reset). FSM keeps waiting.
//   Counter saturates and does not wrap.
//  Reset mid-fetch: outstanding request is dropped and fetch restarts from IDLE.
//   The imem side must also be reset.
// STRUCTURE
//  riscv_pkg: INST_MEMORY_ADDRESS_WIDTH, RISC_V_INST_WIDTH,
//   typedef enum logic [1:0] {IDLE,REQ,HOLD,REDIR} fetch_state_t.
//  Sub-module fetch_timeout_counter (clk, rst, count_en, clear, limit_hit); width $clog2(TIMEOUT_CYCLES+1).
//  Top level holds the FSM, redirect pending register, buf and the inst_data/inst_valid registers.
// TESTING
//  1 Reset release, imem_ack tied 1, rdata=0x00000013: IDLE 1 cycle; inst_valid every cycle from
//    cycle 3; PC 0,4,8,...
//  2 stall=1 for 3 cycles coinciding with ack of PC=0x8: HOLD, PC frozen at 0x8, no inst_valid;
//    stall=0 -> buffered word out, PC 0xC.
//  3 redirect_valid with target 0x40 in HOLD: cycle N+1 pc_src=1, flush=1, pc_target=0x40;
//    next imem_req at PC 0x40; buffered word never appears.
//  4 redirect to 0x80 in REQ, ack 3 cycles later: no inst_valid for that word; REDIR the cycle
//    after ack; PC=0x80. Second redirect to 0x90 before ack -> PC=0x90.
//  5 TIMEOUT_CYCLES=4, imem_ack=0 for 6 cycles: fetch_error=1 after 4th un-acked cycle, stays 1
//    after ack; cleared only by rst=0.
//  6 rst=0 asserted while REQ awaits ack: all outputs at reset values immediately (async);
//    restart fetches from PC 0.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// Shared types and widths for the instruction fetch front end.
// Address/instruction widths and the fetch FSM state encoding.
package fetch_sequencer_pkg;

  localparam int INST_MEMORY_ADDRESS_WIDTH = 32;
  localparam int RISC_V_INST_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD,
    REDIR
  } fetch_state_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory fetch port: request out, ack + read data back.
// Master is the sequencer, slave is the instruction memory.
interface fetch_sequencer_if
  import fetch_sequencer_pkg::*;
#(
  parameter int IW = RISC_V_INST_WIDTH
);

  logic          imem_req;
  logic          imem_ack;
  logic [IW-1:0] imem_rdata;

  modport master (
    output imem_req,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_timeout_counter.sv
// Counts consecutive un-acked fetch cycles, saturating at the limit.
// limit_hit fires in the cycle that reaches the limit (and after).
module fetch_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic count_en,
  input  logic clear,
  output logic limit_hit
);

  localparam int W =
    (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [W-1:0] LIM = W'(TIMEOUT_CYCLES);
  localparam bit EN = (TIMEOUT_CYCLES != 0);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (count_en && (cnt_q != LIM)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // With a zero limit the counter never moves and never reports.
  assign limit_hit = EN && count_en && !clear &&
                     (cnt_d == LIM);

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch control FSM: drives the PC and imem request, delivers
// instructions to decode as single-cycle pulses.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int AW = INST_MEMORY_ADDRESS_WIDTH,
  parameter int IW = RISC_V_INST_WIDTH,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 redirect_valid,
  input  logic [AW-1:0]        redirect_target,
  fetch_sequencer_if.master    imem,
  output logic                 pc_hold,
  output logic                 pc_src,
  output logic [AW-1:0]        pc_target,
  output logic                 inst_valid,
  output logic [IW-1:0]        inst_data,
  output logic                 flush,
  output logic                 fetch_error
);

  fetch_state_t  state_q;
  logic          pend_valid_q;
  logic [AW-1:0] pend_target_q;
  logic [IW-1:0] buf_q;
  logic          inst_valid_q;
  logic [IW-1:0] inst_data_q;
  logic          fetch_error_q;

  logic          req_c;
  logic          redir_any;
  logic          ack;
  logic          to_en;
  logic          to_clr;
  logic          to_hit;

  assign ack       = imem.imem_ack;
  assign redir_any = pend_valid_q | redirect_valid;

  fetch_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .count_en (to_en),
    .clear    (to_clr),
    .limit_hit(to_hit)
  );

  assign to_en  = (state_q == REQ) & ~ack;
  assign to_clr = (state_q != REQ) | ack;

  always_comb begin
    req_c   = 1'b0;
    pc_hold = 1'b1;
    pc_src  = 1'b0;
    flush   = 1'b0;
    unique case (state_q)
      IDLE: begin
      end
      REQ: begin
        req_c   = 1'b1;
        pc_hold = ~(ack & ~redir_any & ~stall);
      end
      HOLD: begin
        pc_hold = redir_any | stall;
      end
      REDIR: begin
        pc_hold = 1'b0;
        pc_src  = 1'b1;
        flush   = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign imem.imem_req = req_c;
  assign pc_target     = pend_target_q;
  assign inst_valid    = inst_valid_q;
  assign inst_data     = inst_data_q;
  assign fetch_error   = fetch_error_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
      buf_q         <= '0;
      inst_valid_q  <= 1'b0;
      inst_data_q   <= '0;
      fetch_error_q <= 1'b0;
    end else begin
      inst_valid_q <= 1'b0;

      // A pulse during REDIR survives the clear and is taken next.
      if (redirect_valid) begin
        pend_valid_q  <= 1'b1;
        pend_target_q <= redirect_target;
      end else if (state_q == REDIR) begin
        pend_valid_q  <= 1'b0;
      end

      if (to_hit) begin
        fetch_error_q <= 1'b1;
      end

      unique case (state_q)
        IDLE: begin
          state_q <= REQ;
        end
        REQ: begin
          if (ack) begin
            if (redir_any) begin
              state_q <= REDIR;
            end else if (stall) begin
              buf_q   <= imem.imem_rdata;
              state_q <= HOLD;
            end else begin
              inst_data_q  <= imem.imem_rdata;
              inst_valid_q <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (redir_any) begin
            state_q <= REDIR;
          end else if (!stall) begin
            inst_data_q  <= buf_q;
            inst_valid_q <= 1'b1;
            state_q      <= REQ;
          end
        end
        REDIR: begin
          state_q <= REQ;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a PC/imem environment
// and a transaction-level reference model checked every cycle.
module tb_fetch_sequencer;

  localparam int AW = fetch_sequencer_pkg::INST_MEMORY_ADDRESS_WIDTH;
  localparam int IW = fetch_sequencer_pkg::RISC_V_INST_WIDTH;
  localparam int TO = 4;

  localparam int M_IDLE  = 0;
  localparam int M_FETCH = 1;
  localparam int M_PARK  = 2;
  localparam int M_JUMP  = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          stall = 1'b0;
  logic          rv = 1'b0;
  logic [AW-1:0] rt = '0;
  logic          ack = 1'b0;

  logic          pc_hold;
  logic          pc_src;
  logic [AW-1:0] pc_target;
  logic          inst_valid;
  logic [IW-1:0] inst_data;
  logic          flush;
  logic          fetch_error;
  logic [AW-1:0] env_pc;

  int checks = 0;
  int errors = 0;

  function automatic logic [IW-1:0] word_of(input logic [AW-1:0] a);
    return {a[19:0], 12'h013};
  endfunction

  fetch_sequencer_if #(.IW(IW)) imem_if ();

  assign imem_if.imem_ack   = ack;
  assign imem_if.imem_rdata = word_of(env_pc);

  fetch_sequencer #(
    .AW(AW),
    .IW(IW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (rv),
    .redirect_target(rt),
    .imem           (imem_if.master),
    .pc_hold        (pc_hold),
    .pc_src         (pc_src),
    .pc_target      (pc_target),
    .inst_valid     (inst_valid),
    .inst_data      (inst_data),
    .flush          (flush),
    .fetch_error    (fetch_error)
  );

  always #5 clk = ~clk;

  // Environment program counter, driven by the DUT like the real one.
  always @(posedge clk or negedge rst) begin
    if (!rst) env_pc <= '0;
    else if (!pc_hold) env_pc <= pc_src ? pc_target : env_pc + AW'(4);
  end

  // Reference model
  int            m_ph;
  logic          m_pend;
  logic [AW-1:0] m_tgt;
  logic [IW-1:0] m_buf;
  logic          m_iv;
  logic [IW-1:0] m_data;
  logic          m_err;
  int            m_tcnt;
  logic [AW-1:0] m_pc;

  logic e_req, e_hold, e_src, e_flush, e_jmp;

  always_comb begin
    e_req   = 1'b0;
    e_hold  = 1'b1;
    e_src   = 1'b0;
    e_flush = 1'b0;
    e_jmp   = m_pend | rv;
    if (m_ph == M_FETCH) begin
      e_req  = 1'b1;
      e_hold = !(ack && !e_jmp && !stall);
    end else if (m_ph == M_PARK) begin
      e_hold = e_jmp || stall;
    end else if (m_ph == M_JUMP) begin
      e_hold  = 1'b0;
      e_src   = 1'b1;
      e_flush = 1'b1;
    end
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_ph   <= M_IDLE;
      m_pend <= 1'b0;
      m_tgt  <= '0;
      m_buf  <= '0;
      m_iv   <= 1'b0;
      m_data <= '0;
      m_err  <= 1'b0;
      m_tcnt <= 0;
      m_pc   <= '0;
    end else begin
      m_iv <= 1'b0;
      if (rv) begin
        m_pend <= 1'b1;
        m_tgt  <= rt;
      end else if (m_ph == M_JUMP) begin
        m_pend <= 1'b0;
      end
      if (!e_hold) m_pc <= e_src ? m_tgt : m_pc + AW'(4);
      if (m_ph == M_FETCH && !ack) begin
        m_tcnt <= (m_tcnt < TO) ? m_tcnt + 1 : TO;
        if (m_tcnt + 1 >= TO) m_err <= 1'b1;
      end else begin
        m_tcnt <= 0;
      end
      if (m_ph == M_IDLE || m_ph == M_JUMP) begin
        m_ph <= M_FETCH;
      end else if (m_ph == M_FETCH && ack) begin
        if (e_jmp) m_ph <= M_JUMP;
        else if (stall) begin
          m_buf <= word_of(m_pc);
          m_ph  <= M_PARK;
        end else begin
          m_iv   <= 1'b1;
          m_data <= word_of(m_pc);
        end
      end else if (m_ph == M_PARK) begin
        if (e_jmp) m_ph <= M_JUMP;
        else if (!stall) begin
          m_iv   <= 1'b1;
          m_data <= m_buf;
          m_ph   <= M_FETCH;
        end
      end
    end
  end

  task automatic chk1(input string nm, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0b exp=%0b t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h t=%0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk1("m_req", imem_if.imem_req, e_req);
    chk1("m_hold", pc_hold, e_hold);
    chk1("m_src", pc_src, e_src);
    chk1("m_flush", flush, e_flush);
    chk32("m_target", pc_target, m_tgt);
    chk1("m_ivalid", inst_valid, m_iv);
    chk32("m_idata", inst_data, m_data);
    chk1("m_ferr", fetch_error, m_err);
    chk32("m_pc", env_pc, m_pc);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2;
    chk1("rst_req", imem_if.imem_req, 1'b0);
    chk1("rst_hold", pc_hold, 1'b1);
    chk1("rst_iv", inst_valid, 1'b0);
    chk1("rst_flush", flush, 1'b0);

    cyc(); rst = 1'b1; ack = 1'b1; #1;
    chk1("t1_idle_hold", pc_hold, 1'b1);
    chk1("t1_idle_req", imem_if.imem_req, 1'b0);
    cyc(); #1;
    chk1("t1_req", imem_if.imem_req, 1'b1);
    chk1("t1_adv", pc_hold, 1'b0);
    cyc(); #1;
    chk1("t1_iv3", inst_valid, 1'b1);
    chk32("t1_d0", inst_data, 32'h0000_0013);
    chk32("t1_pc4", env_pc, 32'h4);
    cyc(); stall = 1'b1; #1;
    chk32("t1_d4", inst_data, 32'h0000_4013);
    chk32("t2_pc8", env_pc, 32'h8);
    cyc(); #1;
    chk1("t2_noiv", inst_valid, 1'b0);
    chk1("t2_noreq", imem_if.imem_req, 1'b0);
    cyc();
    cyc(); stall = 1'b0; #1;
    chk32("t2_frozen", env_pc, 32'h8);
    cyc(); stall = 1'b1; #1;
    chk1("t2_bufout", inst_valid, 1'b1);
    chk32("t2_bufword", inst_data, 32'h0000_8013);
    chk32("t2_pcC", env_pc, 32'hC);

    cyc(); rv = 1'b1; rt = 32'h40; #1;
    chk1("t3_hold", pc_hold, 1'b1);
    cyc(); rv = 1'b0; stall = 1'b0; #1;
    chk1("t3_src", pc_src, 1'b1);
    chk1("t3_flush", flush, 1'b1);
    chk32("t3_tgt", pc_target, 32'h40);
    chk1("t3_noiv", inst_valid, 1'b0);
    cyc(); #1;
    chk1("t3_req", imem_if.imem_req, 1'b1);
    chk32("t3_pc", env_pc, 32'h40);

    cyc(); ack = 1'b0; rv = 1'b1; rt = 32'h80; #1;
    chk32("t3_word", inst_data, 32'h0004_0013);
    chk32("t4_pc44", env_pc, 32'h44);
    cyc(); rv = 1'b0;
    cyc();
    cyc(); ack = 1'b1; #1;
    chk1("t4_ackhold", pc_hold, 1'b1);
    cyc(); #1;
    chk1("t4_src", pc_src, 1'b1);
    chk32("t4_tgt", pc_target, 32'h80);
    chk1("t4_drop", inst_valid, 1'b0);
    cyc(); ack = 1'b0; rv = 1'b1; rt = 32'h100; #1;
    chk32("t4_pc80", env_pc, 32'h80);
    cyc(); rt = 32'h90;
    cyc(); rv = 1'b0; ack = 1'b1;
    cyc(); #1;
    chk32("t4_tgt90", pc_target, 32'h90);
    cyc(); #1;
    chk32("t4_pc90", env_pc, 32'h90);

    cyc(); ack = 1'b0; #1;
    chk32("t4_w90", inst_data, 32'h0009_0013);
    cyc();
    cyc();
    cyc(); #1;
    chk1("t5_err_pre", fetch_error, 1'b0);
    cyc(); #1;
    chk1("t5_err_set", fetch_error, 1'b1);
    cyc();
    cyc(); ack = 1'b1;
    cyc(); ack = 1'b0; #1;
    chk1("t5_sticky", fetch_error, 1'b1);
    chk32("t5_w94", inst_data, 32'h0009_4013);

    cyc(); #2; rst = 1'b0; #1;
    chk1("t6_req", imem_if.imem_req, 1'b0);
    chk1("t6_hold", pc_hold, 1'b1);
    chk1("t6_src", pc_src, 1'b0);
    chk1("t6_iv", inst_valid, 1'b0);
    chk32("t6_data", inst_data, 32'h0);
    chk1("t6_err", fetch_error, 1'b0);
    chk32("t6_tgt", pc_target, 32'h0);
    cyc(); rst = 1'b1; ack = 1'b1;
    cyc(); #1;
    chk32("t6_pc0", env_pc, 32'h0);
    chk1("t6_req2", imem_if.imem_req, 1'b1);
    cyc(); #1;
    chk32("t6_d0", inst_data, 32'h0000_0013);
    chk32("t6_pc4", env_pc, 32'h4);
    repeat (4) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

endmodule
